// File: rtl/solver_arb_pkg.sv
// Shared definitions for the 8-queen solver arbiter: FSM state encodings,
// default board size and width helpers.
package solver_arb_pkg;

  localparam int DEFAULT_N = 8;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GRANT     = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_CAPTURE   = 3'd4;
  localparam logic [2:0] ST_DRAIN     = 3'd5;

  // Width of a column/row index for an n x n board
  function automatic int col_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a requester index for n requesters
  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational search for the first set request after
// the last winner (with wrap), pointer updated on a grant strobe.
module rr_arbiter
  import solver_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               user_reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               grant_stb,
  output logic               pick_valid,
  output logic [ID_W-1:0]    pick_id
);

  logic [ID_W-1:0]    rr_ptr_reg;
  logic [ID_W-1:0]    cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // Candidate gi is the requester gi+1 positions after the pointer, wrapped
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign sum      = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi + 1);
      assign cand[gi] = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                    : sum[ID_W-1:0];
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Lowest offset from the pointer wins
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pick_valid = 1'b1;
        pick_id    = cand[i];
      end
    end
  end

  // Pointer starts at the last requester so req[0] has priority first
  always_ff @(posedge clk or posedge user_reset) begin
    if (user_reset) begin
      rr_ptr_reg <= ID_W'(NUM_REQ - 1);
    end else if (grant_stb && pick_valid) begin
      rr_ptr_reg <= pick_id;
    end
  end

endmodule

// File: rtl/solver_arbiter.sv
// Shares one 8-queen solver between NUM_REQ clients: round-robin grant,
// start pulse, capture of the N-beat column burst, then drain to the winner.
// Optional watchdog on WAIT_DONE enabled by defining SOLVER_WATCHDOG_EN.
module solver_arbiter
  import solver_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  N       = DEFAULT_N,
  parameter int  TIMEOUT = 4096,
  localparam int COL_W   = col_w(N),
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               user_reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  input  logic               solver_ready,
  output logic               solver_start,
  input  logic               solver_done,
  input  logic               solver_out_en,
  input  logic [COL_W-1:0]   solver_col,
  output logic               solver_abort,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [COL_W-1:0]   res_row,
  output logic [COL_W-1:0]   res_col,
  output logic [ID_W-1:0]    res_id,
  output logic               res_last,
  output logic               res_err
);

  localparam logic [COL_W-1:0] LAST_IDX = COL_W'(N - 1);

  logic [2:0]         state_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [ID_W-1:0]    res_id_reg;
  logic               start_reg;
  logic [COL_W-1:0]   wr_ptr_reg;
  logic [COL_W-1:0]   rd_ptr_reg;
  logic [COL_W-1:0]   buf_mem [N];
  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;
  logic               err_flag;
  logic               drain;
  logic               beat_last;

`ifdef SOLVER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_reg;
  logic            abort_reg;
  logic            err_reg;
  assign err_flag     = err_reg;
  assign solver_abort = abort_reg;
`else
  assign err_flag     = 1'b0;
  assign solver_abort = 1'b0;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk        (clk),
    .user_reset (user_reset),
    .req        (req),
    .grant_stb  (state_reg == ST_GRANT),
    .pick_valid (pick_valid),
    .pick_id    (pick_id)
  );

  assign drain     = (state_reg == ST_DRAIN);
  assign beat_last = err_flag || (rd_ptr_reg == LAST_IDX);

  // Service sequencing: grant, start pulse, wait, capture, drain
  always_ff @(posedge clk or posedge user_reset) begin
    if (user_reset) begin
      state_reg  <= ST_IDLE;
      gnt_reg    <= '0;
      res_id_reg <= '0;
      start_reg  <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
`ifdef SOLVER_WATCHDOG_EN
      wd_cnt_reg <= '0;
      abort_reg  <= 1'b0;
      err_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req && solver_ready) state_reg <= ST_GRANT;
        end
        ST_GRANT: begin
          if (pick_valid) begin
            gnt_reg    <= NUM_REQ'(1) << pick_id;
            res_id_reg <= pick_id;
            state_reg  <= ST_START;
          end else begin
            // Request vanished before arbitration; nothing to serve
            state_reg <= ST_IDLE;
          end
`ifdef SOLVER_WATCHDOG_EN
          err_reg <= 1'b0;
`endif
        end
        ST_START: begin
          start_reg <= 1'b1;
          state_reg <= ST_WAIT_DONE;
`ifdef SOLVER_WATCHDOG_EN
          wd_cnt_reg <= '0;
`endif
        end
        ST_WAIT_DONE: begin
          start_reg <= 1'b0;
          if (solver_done) begin
            wr_ptr_reg <= '0;
            state_reg  <= ST_CAPTURE;
          end
`ifdef SOLVER_WATCHDOG_EN
          else if (wd_cnt_reg == WD_W'(TIMEOUT - 1)) begin
            abort_reg  <= 1'b1;
            err_reg    <= 1'b1;
            rd_ptr_reg <= '0;
            state_reg  <= ST_DRAIN;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
          end
`endif
        end
        ST_CAPTURE: begin
          if (solver_out_en) begin
            wr_ptr_reg <= wr_ptr_reg + COL_W'(1);
            if (wr_ptr_reg == LAST_IDX) begin
              rd_ptr_reg <= '0;
              state_reg  <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
`ifdef SOLVER_WATCHDOG_EN
          abort_reg <= 1'b0;
`endif
          if (res_ready) begin
            if (beat_last) begin
              gnt_reg   <= '0;
              state_reg <= ST_IDLE;
            end else begin
              rd_ptr_reg <= rd_ptr_reg + COL_W'(1);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Burst buffer; contents are only meaningful between CAPTURE and DRAIN
  always_ff @(posedge clk) begin
    if (state_reg == ST_CAPTURE && solver_out_en) begin
      buf_mem[wr_ptr_reg] <= solver_col;
    end
  end

  // Result port is driven only in DRAIN; an aborted service yields row 0, col 0
  always_comb begin
    res_valid = drain;
    res_last  = drain && beat_last;
    res_err   = drain && err_flag;
    res_row   = '0;
    res_col   = '0;
    if (drain && !err_flag) begin
      res_row = rd_ptr_reg;
      res_col = buf_mem[rd_ptr_reg];
    end
  end

  assign gnt          = gnt_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign solver_start = start_reg;
  assign res_id       = res_id_reg;

endmodule

// File: tb/tb_solver_arbiter.sv
// Directed bench for solver_arbiter with a behavioural solver model.
// Define SOLVER_WATCHDOG_EN to also exercise the watchdog (TIMEOUT=100).
module tb_solver_arbiter;

  localparam int NUM_REQ = 4;
  localparam int N       = 8;

  logic               clk = 1'b0;
  logic               user_reset = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] gnt;
  logic               busy;
  logic               solver_ready = 1'b1;
  logic               solver_start;
  logic               solver_done = 1'b0;
  logic               solver_out_en = 1'b0;
  logic [2:0]         solver_col = '0;
  logic               solver_abort;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [2:0]         res_row;
  logic [2:0]         res_col;
  logic [1:0]         res_id;
  logic               res_last;
  logic               res_err;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  bit model_en = 1'b1;
  logic [2:0] burst_col [N] = '{3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3};

  solver_arbiter #(.NUM_REQ(NUM_REQ), .N(N), .TIMEOUT(100)) dut (
    .clk           (clk),
    .user_reset    (user_reset),
    .req           (req),
    .gnt           (gnt),
    .busy          (busy),
    .solver_ready  (solver_ready),
    .solver_start  (solver_start),
    .solver_done   (solver_done),
    .solver_out_en (solver_out_en),
    .solver_col    (solver_col),
    .solver_abort  (solver_abort),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_row       (res_row),
    .res_col       (res_col),
    .res_id        (res_id),
    .res_last      (res_last),
    .res_err       (res_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Solver model: two cycles after start, pulse done, then stream the burst
  always begin
    tick();
    if (solver_start === 1'b1 && model_en) begin
      tick();
      tick();
      solver_done = 1'b1;
      tick();
      solver_done = 1'b0;
      for (int k = 0; k < N; k++) begin
        solver_out_en = 1'b1;
        solver_col    = burst_col[k];
        tick();
      end
      solver_out_en = 1'b0;
    end
  end

  // Count start pulses
  always @(negedge clk) if (solver_start === 1'b1) start_cnt++;

  task automatic do_reset();
    req        = '0;
    res_ready  = 1'b0;
    user_reset = 1'b1;
    repeat (12) tick();
    user_reset = 1'b0;
    tick();
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (gnt === '0 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (gnt === '0) begin
      errors++;
      $display("FAIL wait_gnt: no grant within %0d cycles, gnt=%b required nonzero", n, gnt);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (res_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid: res_valid=%b after %0d cycles, required 1", res_valid, n);
    end
  endtask

  // Accept all N beats, checking row/col/id/last/err, then the return to IDLE
  task automatic drain_check(input logic [1:0] exp_id);
    int got = 0;
    logic [2:0] exp_row;
    res_ready = 1'b1;
    for (int g = 0; g < 300 && got < N; g++) begin
      if (res_valid === 1'b1) begin
        exp_row = got[2:0];
        checks += 5;
        if (res_row !== exp_row) begin
          errors++;
          $display("FAIL beat_row: got %0d required %0d", res_row, exp_row);
        end
        if (res_col !== burst_col[got]) begin
          errors++;
          $display("FAIL beat_col row %0d: got %0d required %0d", got, res_col, burst_col[got]);
        end
        if (res_id !== exp_id) begin
          errors++;
          $display("FAIL beat_id row %0d: got %0d required %0d", got, res_id, exp_id);
        end
        if (res_last !== (got == N - 1)) begin
          errors++;
          $display("FAIL beat_last row %0d: got %b required %b", got, res_last, (got == N - 1));
        end
        if (res_err !== 1'b0) begin
          errors++;
          $display("FAIL beat_err row %0d: got %b required 0", got, res_err);
        end
        $display("beat id=%0d row=%0d col=%0d last=%b", res_id, res_row, res_col, res_last);
        got++;
      end
      tick();
    end
    res_ready = 1'b0;
    checks += 3;
    if (got != N) begin
      errors++;
      $display("FAIL beat_count: got %0d required %0d", got, N);
    end
    if (gnt !== '0) begin
      errors++;
      $display("FAIL gnt_after_drain: got %b required 0000", gnt);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_drain: got %b required 0", busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (gnt !== '0 || busy !== 1'b0 || solver_start !== 1'b0 || solver_abort !== 1'b0 ||
        res_valid !== 1'b0 || res_row !== '0 || res_col !== '0 || res_id !== '0 ||
        res_last !== 1'b0 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: gnt=%b busy=%b start=%b abort=%b valid=%b row=%0d col=%0d id=%0d last=%b err=%b required all 0",
               tag, gnt, busy, solver_start, solver_abort, res_valid, res_row, res_col, res_id, res_last, res_err);
    end
    $display("%s checked", tag);
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_outputs("reset_state");
  endtask

  task automatic test_single();
    int base;
    do_reset();
    base = start_cnt;
    req = 4'b0100;
    tick();
    checks += 2;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL single_gnt_early: got %b required 0000", gnt);
    end
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %b required 1", busy);
    end
    tick();
    checks += 2;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL single_gnt: got %b required 0100", gnt);
    end
    if (solver_start !== 1'b0) begin
      errors++;
      $display("FAIL single_start_early: got %b required 0", solver_start);
    end
    tick();
    checks++;
    if (solver_start !== 1'b1) begin
      errors++;
      $display("FAIL single_start: got %b required 1", solver_start);
    end
    req = '0;
    tick();
    checks++;
    if (solver_start !== 1'b0) begin
      errors++;
      $display("FAIL single_start_width: got %b required 0", solver_start);
    end
    drain_check(2'd2);
    checks++;
    if (start_cnt - base != 1) begin
      errors++;
      $display("FAIL single_start_count: got %0d required 1", start_cnt - base);
    end
    $display("single service done");
  endtask

  task automatic test_round_robin();
    logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_gnt;
    do_reset();
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      wait_gnt();
      exp_gnt = 4'b0001 << order[s];
      checks += 2;
      if (gnt !== exp_gnt) begin
        errors++;
        $display("FAIL rr_gnt service %0d: got %b required %b", s, gnt, exp_gnt);
      end
      if (res_id !== order[s]) begin
        errors++;
        $display("FAIL rr_id service %0d: got %0d required %0d", s, res_id, order[s]);
      end
      $display("rr service %0d gnt=%b", s, gnt);
      drain_check(order[s]);
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0001;
    wait_gnt();
    req = '0;
    wait_valid();
    for (int c = 0; c < 10; c++) begin
      checks += 3;
      if (res_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_valid cycle %0d: got %b required 1", c, res_valid);
      end
      if (res_row !== 3'd0) begin
        errors++;
        $display("FAIL bp_row cycle %0d: got %0d required 0", c, res_row);
      end
      if (res_col !== burst_col[0]) begin
        errors++;
        $display("FAIL bp_col cycle %0d: got %0d required %0d", c, res_col, burst_col[0]);
      end
      tick();
    end
    $display("backpressure hold done");
    drain_check(2'd0);
  endtask

  task automatic test_drop_req();
    int n = 0;
    do_reset();
    req = 4'b0010;
    wait_gnt();
    while (solver_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    req = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_busy: got %b required 1", busy);
    end
    drain_check(2'd1);
    $display("drop request service done");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    req = 4'b1111;
    while (solver_out_en !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before: got %b required 1", busy);
    end
    user_reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    repeat (12) tick();
    user_reset = 1'b0;
    wait_gnt();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL mid_regrant: got %b required 0001", gnt);
    end
    drain_check(2'd0);
    req = '0;
  endtask

`ifdef SOLVER_WATCHDOG_EN
  task automatic test_watchdog();
    int n = 0;
    int c = 0;
    model_en = 1'b0;
    do_reset();
    req = 4'b0100;
    while (solver_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    req = '0;
    while (solver_abort !== 1'b1 && c < 300) begin
      tick();
      c++;
    end
    checks += 7;
    if (c != 100) begin
      errors++;
      $display("FAIL wd_abort_delay: got %0d required 100", c);
    end
    if (res_valid !== 1'b1 || res_err !== 1'b1 || res_last !== 1'b1) begin
      errors++;
      $display("FAIL wd_beat_flags: valid=%b err=%b last=%b required 1 1 1", res_valid, res_err, res_last);
    end
    if (res_row !== 3'd0) begin
      errors++;
      $display("FAIL wd_row: got %0d required 0", res_row);
    end
    if (res_col !== 3'd0) begin
      errors++;
      $display("FAIL wd_col: got %0d required 0", res_col);
    end
    if (res_id !== 2'd2) begin
      errors++;
      $display("FAIL wd_id: got %0d required 2", res_id);
    end
    res_ready = 1'b1;
    tick();
    if (solver_abort !== 1'b0) begin
      errors++;
      $display("FAIL wd_abort_width: got %b required 0", solver_abort);
    end
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL wd_idle: busy=%b valid=%b required 0 0", busy, res_valid);
    end
    res_ready = 1'b0;
    $display("watchdog service done after %0d cycles", c);
    model_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drop_req();
    test_reset_mid();
`ifdef SOLVER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
